// File: rtl/nlm_pkg.sv
// Shared encodings and size helpers for the NLM output normaliser.
package nlm_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_DENOISE = 2'd1,
        MODE_BLEND   = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    localparam int STR_W   = 5;
    localparam int STR_MAX = 16;

    // One capture/range-check stage ahead of the bit stages, blend and output register after.
    localparam int PRE_STAGES  = 1;
    localparam int POST_STAGES = 2;

    function automatic int latency(input int data_w);
        return PRE_STAGES + data_w + POST_STAGES;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_COL_W = cnt_w(1920);
    localparam int DEF_ROW_W = cnt_w(1080);

endpackage

// File: rtl/nlm_div_pipe.sv
// Pipelined restoring divider, one quotient bit per stage, with an opaque sideband tag.
// Dividend high part must fit the divisor width (NUM_W - QUO_W == DEN_W).
module nlm_div_pipe #(
    parameter int NUM_W = 26,
    parameter int DEN_W = 14,
    parameter int QUO_W = 12,
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [QUO_W-1:0] quo_o,
    output logic             dz_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [QUO_W:0]            vld_pipe_q, vld_pipe_d;
    logic [QUO_W:0]            ovf_q, ovf_d, dz_q, dz_d;
    logic [QUO_W:0][DEN_W-1:0] rem_q, rem_d, den_q, den_d;
    logic [QUO_W:0][QUO_W-1:0] lo_q, lo_d, quo_q, quo_d;
    logic [QUO_W:0][TAG_W-1:0] tag_q, tag_d;
    logic [DEN_W:0]            trial;
    logic                      ge;

    always_comb begin
        vld_pipe_d = '0;
        ovf_d      = '0;
        dz_d       = '0;
        rem_d      = '0;
        den_d      = '0;
        lo_d       = '0;
        quo_d      = '0;
        tag_d      = '0;
        trial      = '0;
        ge         = 1'b0;

        // Entry stage: a quotient >= 2^QUO_W shows up as high dividend >= divisor.
        vld_pipe_d[0] = valid_i;
        rem_d[0]      = num_i[NUM_W-1:QUO_W];
        lo_d[0]       = num_i[QUO_W-1:0];
        den_d[0]      = den_i;
        dz_d[0]       = (den_i == '0);
        ovf_d[0]      = (num_i[NUM_W-1:QUO_W] >= den_i);
        tag_d[0]      = tag_i;

        for (int k = 1; k <= QUO_W; k++) begin
            trial         = {rem_q[k-1], lo_q[k-1][QUO_W-1]};
            ge            = (trial >= {1'b0, den_q[k-1]});
            rem_d[k]      = ge ? DEN_W'(trial - {1'b0, den_q[k-1]}) : trial[DEN_W-1:0];
            lo_d[k]       = lo_q[k-1] << 1;
            den_d[k]      = den_q[k-1];
            quo_d[k]      = (quo_q[k-1] << 1) | QUO_W'(ge);
            vld_pipe_d[k] = vld_pipe_q[k-1];
            ovf_d[k]      = ovf_q[k-1];
            dz_d[k]       = dz_q[k-1];
            tag_d[k]      = tag_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            ovf_q      <= '0;
            dz_q       <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            lo_q       <= '0;
            quo_q      <= '0;
            tag_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            ovf_q      <= ovf_d;
            dz_q       <= dz_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            lo_q       <= lo_d;
            quo_q      <= quo_d;
            tag_q      <= tag_d;
        end
    end

    logic unused_tail;
    assign unused_tail = ^{rem_q[QUO_W], den_q[QUO_W], lo_q[QUO_W]};

    assign valid_o = vld_pipe_q[QUO_W];
    assign quo_o   = ovf_q[QUO_W] ? '1 : quo_q[QUO_W];
    assign dz_o    = dz_q[QUO_W];
    assign tag_o   = tag_q[QUO_W];

endmodule

// File: rtl/nlm_out_norm.sv
// NLM output normaliser: divides the weighted pixel sum by the weight sum,
// applies per-frame mode/strength, and passes border pixels through untouched.
module nlm_out_norm
    import nlm_pkg::*;
#(
    parameter int DATA_WIDTH   = 12,
    parameter int SUM_WIDTH    = 26,
    parameter int WSUM_WIDTH   = 14,
    parameter int IMAGE_WIDTH  = 1920,
    parameter int IMAGE_HEIGHT = 1080,
    parameter int BORDER       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [SUM_WIDTH-1:0]  pix_sum_i,
    input  logic [WSUM_WIDTH-1:0] weight_sum_i,
    input  logic [DATA_WIDTH-1:0] pix_i,
    input  logic [1:0]            mode_i,
    input  logic [STR_W-1:0]      strength_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] pix_original,
    output logic [DATA_WIDTH-1:0] pix_denoise,
    output logic                  line_sync_o,
    output logic                  frame_sync_o
);

    localparam int CW    = cnt_w(IMAGE_WIDTH);
    localparam int RW    = cnt_w(IMAGE_HEIGHT);
    localparam int ACC_W = DATA_WIDTH + 5;
    localparam logic [STR_W-1:0] SMAX = STR_W'(STR_MAX);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pix;
        mode_e                 mode;
        logic [STR_W-1:0]      str;
        logic                  border;
        logic                  line;
        logic                  frame;
    } tag_t;

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    mode_e            mode_sh_q, mode_sh_d;
    logic [STR_W-1:0] str_sh_q, str_sh_d;
    logic             sof, border;
    tag_t             tag_in;

    // The (0,0) beat itself already uses the freshly captured settings, hence mode_sh_d in the tag.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        mode_sh_d = mode_sh_q;
        str_sh_d  = str_sh_q;
        sof       = (col_q == '0) && (row_q == '0);
        if (valid_i) begin
            if (col_q == CW'(IMAGE_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMAGE_HEIGHT - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (sof) begin
                mode_sh_d = mode_e'(mode_i);
                str_sh_d  = (strength_i > SMAX) ? SMAX : strength_i;
            end
        end
        border = (int'(col_q) < BORDER) || (int'(col_q) >= IMAGE_WIDTH - BORDER) ||
                 (int'(row_q) < BORDER) || (int'(row_q) >= IMAGE_HEIGHT - BORDER);
        tag_in.pix    = pix_i;
        tag_in.mode   = mode_sh_d;
        tag_in.str    = str_sh_d;
        tag_in.border = border;
        tag_in.line   = (col_q == '0);
        tag_in.frame  = sof;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            mode_sh_q <= MODE_BYPASS;
            str_sh_q  <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            mode_sh_q <= mode_sh_d;
            str_sh_q  <= str_sh_d;
        end
    end

    logic                  dv_vld, dv_dz;
    logic [DATA_WIDTH-1:0] dv_quo;
    tag_t                  dv_tag;

    nlm_div_pipe #(
        .NUM_W(SUM_WIDTH),
        .DEN_W(WSUM_WIDTH),
        .QUO_W(DATA_WIDTH),
        .TAG_W($bits(tag_t))
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .num_i   (pix_sum_i),
        .den_i   (weight_sum_i),
        .tag_i   (tag_in),
        .valid_o (dv_vld),
        .quo_o   (dv_quo),
        .dz_o    (dv_dz),
        .tag_o   (dv_tag)
    );

    logic [DATA_WIDTH-1:0] q_sel;
    logic [ACC_W-1:0]      acc;
    logic                  b_vld_q, b_vld_d, b_line_q, b_line_d, b_frame_q, b_frame_d;
    logic [DATA_WIDTH-1:0] b_pix_q, b_pix_d, b_den_q, b_den_d;

    always_comb begin
        q_sel     = dv_dz ? dv_tag.pix : dv_quo;
        acc       = ACC_W'(q_sel) * ACC_W'(dv_tag.str) +
                    ACC_W'(dv_tag.pix) * ACC_W'(SMAX - dv_tag.str) + ACC_W'(8);
        case (dv_tag.mode)
            MODE_DENOISE: b_den_d = q_sel;
            MODE_BLEND:   b_den_d = acc[DATA_WIDTH+3:4];
            default:      b_den_d = dv_tag.pix;
        endcase
        if (dv_tag.border) b_den_d = dv_tag.pix;
        b_vld_d   = dv_vld;
        b_pix_d   = dv_tag.pix;
        b_line_d  = dv_tag.line;
        b_frame_d = dv_tag.frame;
    end

    // Blend sum peaks at 16*(2^DATA_WIDTH-1)+8, so the accumulator MSB never sets.
    logic unused_acc_msb;
    assign unused_acc_msb = acc[ACC_W-1];

    logic                  vld_o_q, vld_o_d, line_sync_q, line_sync_d, frame_sync_q, frame_sync_d;
    logic [DATA_WIDTH-1:0] pix_orig_q, pix_orig_d, pix_den_q, pix_den_d;

    always_comb begin
        vld_o_d      = b_vld_q;
        pix_orig_d   = b_vld_q ? b_pix_q : pix_orig_q;
        pix_den_d    = b_vld_q ? b_den_q : pix_den_q;
        line_sync_d  = b_vld_q & b_line_q;
        frame_sync_d = b_vld_q & b_frame_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_vld_q      <= 1'b0;
            b_line_q     <= 1'b0;
            b_frame_q    <= 1'b0;
            b_pix_q      <= '0;
            b_den_q      <= '0;
            vld_o_q      <= 1'b0;
            line_sync_q  <= 1'b0;
            frame_sync_q <= 1'b0;
            pix_orig_q   <= '0;
            pix_den_q    <= '0;
        end else begin
            b_vld_q      <= b_vld_d;
            b_line_q     <= b_line_d;
            b_frame_q    <= b_frame_d;
            b_pix_q      <= b_pix_d;
            b_den_q      <= b_den_d;
            vld_o_q      <= vld_o_d;
            line_sync_q  <= line_sync_d;
            frame_sync_q <= frame_sync_d;
            pix_orig_q   <= pix_orig_d;
            pix_den_q    <= pix_den_d;
        end
    end

    assign valid_o      = vld_o_q;
    assign pix_original = pix_orig_q;
    assign pix_denoise  = pix_den_q;
    assign line_sync_o  = line_sync_q;
    assign frame_sync_o = frame_sync_q;

endmodule

// File: tb/tb_nlm_out_norm.sv
// Directed bench for nlm_out_norm on a 32x16 frame with a 2-pixel border.
module tb_nlm_out_norm;

    localparam int DW = 12, SW = 26, WW = 14, IW = 32, IH = 16, BD = 2, LAT = 15;

    logic          clk = 1'b0, rst = 1'b1, valid_i = 1'b0;
    logic [SW-1:0] pix_sum_i = '0;
    logic [WW-1:0] weight_sum_i = '0;
    logic [DW-1:0] pix_i = '0;
    logic [1:0]    mode_i = '0;
    logic [4:0]    strength_i = '0;
    logic          valid_o, line_sync_o, frame_sync_o;
    logic [DW-1:0] pix_original, pix_denoise;

    nlm_out_norm #(
        .DATA_WIDTH(DW), .SUM_WIDTH(SW), .WSUM_WIDTH(WW),
        .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .BORDER(BD)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pix_sum_i(pix_sum_i),
        .weight_sum_i(weight_sum_i), .pix_i(pix_i), .mode_i(mode_i),
        .strength_i(strength_i), .valid_o(valid_o), .pix_original(pix_original),
        .pix_denoise(pix_denoise), .line_sync_o(line_sync_o), .frame_sync_o(frame_sync_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int cyc;
        int orig;
        int den;
        bit line;
        bit frame;
        bit dir;
    } exp_t;

    exp_t expq[$];
    int   col = 0, row = 0, sh_mode = 0, sh_str = 0;
    int   n_line = 0, n_frame = 0;

    function automatic int model_den(input int sum, input int ws, input int pix, input bit brd);
        int q;
        if (brd || !(sh_mode == 1 || sh_mode == 2)) return pix;
        q = (ws == 0) ? pix : sum / ws;
        if (q > 4095) q = 4095;
        if (sh_mode == 1) return q;
        return (q * sh_str + pix * (16 - sh_str) + 8) >> 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sum, input int ws, input int pix, input int mode,
                        input int str, input int exp_den, input bit gaps);
        exp_t e;
        bit   brd;
        if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
        if (col == 0 && row == 0) begin
            sh_mode = mode;
            sh_str  = (str > 16) ? 16 : str;
        end
        brd     = (col < BD) || (col >= IW - BD) || (row < BD) || (row >= IH - BD);
        e.cyc   = cyc;
        e.orig  = pix;
        e.line  = (col == 0);
        e.frame = (col == 0) && (row == 0);
        e.dir   = (exp_den >= 0);
        e.den   = e.dir ? exp_den : model_den(sum, ws, pix, brd);
        pix_sum_i    = SW'(sum);
        weight_sum_i = WW'(ws);
        pix_i        = DW'(pix);
        mode_i       = 2'(mode);
        strength_i   = 5'(str);
        valid_i      = 1'b1;
        expq.push_back(e);
        tick();
        valid_i = 1'b0;
        if (col == IW - 1) begin
            col = 0;
            row = (row == IH - 1) ? 0 : row + 1;
        end else begin
            col++;
        end
    endtask

    // Rows 0..7 present m0/s0, rows 8..15 present m1/s1: only the (0,0) beat may latch them.
    task automatic run_frame(input int fid, input int m0, input int s0, input int m1, input int s1);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                int m   = (r < 8) ? m0 : m1;
                int s   = (r < 8) ? s0 : s1;
                int ws  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4000);
                int sum = $urandom_range(0, 1 << 22);
                int pix = $urandom_range(0, 4095);
                int ex  = -1;
                if (c == 5 && r == 3) begin
                    case (fid)
                        0: begin sum = 40960; ws = 16; pix = 321;  ex = 2560; end
                        1: begin sum = 40960; ws = 16; pix = 100;  ex = 100;  end
                        2: begin sum = 16000; ws = 16; pix = 2000; ex = 1500; end
                        default: begin sum = 16000; ws = 16; pix = 2000; ex = 1000; end
                    endcase
                end
                if (fid == 0) begin
                    if (c == 6 && r == 3) begin sum = 12345; ws = 0; pix = 777; ex = 777; end
                    if (c == 7 && r == 3) begin sum = 1 << 25; ws = 1; pix = 5; ex = 4095; end
                    if (c == 5 && r == 9) begin sum = 40960; ws = 16; pix = 50; ex = 2560; end
                    if ((r == 5 && (c == 1 || c == 30)) || (c == 5 && (r == 1 || r == 14))) begin
                        sum = 40960; ws = 16; pix = 123; ex = 123;
                    end
                end
                if (fid == 2 && c == 1 && r == 5) begin sum = 16000; ws = 16; pix = 2000; ex = 2000; end
                send(sum, ws, pix, m, s, ex, 1'b1);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && expq.size() > 0; i++) tick();
        repeat (2) tick();
        chk(tag, expq.size(), 0);
    endtask

    exp_t mon_e;
    int   last_den = 0, last_orig = 0;

    always @(negedge clk) begin
        if (rst) begin
            last_den  = 0;
            last_orig = 0;
        end else if (valid_o) begin
            if (expq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                chk("latency", cyc - mon_e.cyc, LAT);
                chk("orig", pix_original, mon_e.orig);
                chk(mon_e.dir ? "den_directed" : "den_model", pix_denoise, mon_e.den);
                chk("line_sync", line_sync_o, mon_e.line);
                chk("frame_sync", frame_sync_o, mon_e.frame);
            end
            if (line_sync_o)  n_line++;
            if (frame_sync_o) n_frame++;
            last_den  = pix_denoise;
            last_orig = pix_original;
        end else begin
            chk("idle_sync", {line_sync_o, frame_sync_o}, 0);
            chk("hold_den", pix_denoise, last_den);
            chk("hold_orig", pix_original, last_orig);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_valid", valid_o, 0);
        chk("rst_orig", pix_original, 0);
        chk("rst_den", pix_denoise, 0);
        chk("rst_line", line_sync_o, 0);
        chk("rst_frame", frame_sync_o, 0);
        tick();
        rst = 1'b0;
        tick();

        run_frame(0, 1, 0, 0, 0);
        drain("drain_f0");
        chk("lines_f0", n_line, 16);
        chk("frames_f0", n_frame, 1);

        run_frame(1, 0, 0, 2, 8);
        drain("drain_f1");
        chk("lines_f1", n_line, 32);
        chk("frames_f1", n_frame, 2);

        run_frame(2, 2, 8, 2, 31);
        drain("drain_f2");
        chk("lines_f2", n_line, 48);
        chk("frames_f2", n_frame, 3);

        run_frame(3, 2, 31, 3, 0);
        drain("drain_f3");
        chk("lines_f3", n_line, 64);
        chk("frames_f3", n_frame, 4);

        for (int i = 0; i < 10; i++)
            send($urandom_range(0, 1 << 20), $urandom_range(1, 300), $urandom_range(0, 4095), 1, 0, -1, 1'b0);
        rst = 1'b1;
        expq.delete();
        col = 0; row = 0; sh_mode = 0; sh_str = 0;
        #1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_den", pix_denoise, 0);
        chk("midrst_orig", pix_original, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("midrst_flushed_frames", n_frame, 4);

        for (int i = 0; i < 40; i++)
            send($urandom_range(0, 1 << 22), $urandom_range(0, 4000), $urandom_range(0, 4095), 1, 0, -1, 1'b1);
        drain("drain_post_rst");
        chk("lines_post_rst", n_line, 66);
        chk("frames_post_rst", n_frame, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
